// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency, single-port RAM between instruction fetch and the
// data-memory stage, sequencing each access and freezing the pipeline meanwhile.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_cancel,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [3:0] LAT_INIT = 4'(MEM_LAT);

  state_t     state_r;
  state_t     nextState_s;
  logic [3:0] cnt_r;
  logic       ownerMem_r;
  logic       lastGrantMem_r;
  logic       isWrite_r;
  logic       cancel_r;
  logic       memReq_s;
  logic       grantMem_s;
  logic       cancelHit_s;
  logic       lastWait_s;

  assign memReq_s    = mem_rd | mem_wr;
  assign lastWait_s  = (state_r == WAIT) && (cnt_r == 4'd1);
  assign cancelHit_s = if_cancel & ~ownerMem_r & (state_r != IDLE);

  assign stall_mem = memReq_s & ~mem_ready;
  assign stall_if  = (if_req & ~if_ready) | stall_mem;

  // Grant selection: a lone requester wins; on contention the port not granted last wins.
  always_comb begin
    grantMem_s = 1'b0;
    if (memReq_s && if_req) begin
      grantMem_s = ~lastGrantMem_r;
    end else if (memReq_s) begin
      grantMem_s = 1'b1;
    end else begin
      grantMem_s = 1'b0;
    end
  end

  // Next-state logic of the transaction sequencer.
  always_comb begin
    nextState_s = state_r;
    case (state_r)
      IDLE: begin
        if (if_req || memReq_s) begin
          nextState_s = CMD;
        end else begin
          nextState_s = IDLE;
        end
      end
      CMD:  nextState_s = WAIT;
      WAIT: begin
        if (cnt_r == 4'd1) begin
          nextState_s = RESP;
        end else begin
          nextState_s = WAIT;
        end
      end
      RESP:    nextState_s = IDLE;
      default: nextState_s = IDLE;
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= nextState_s;
    end
  end

  // Grant bookkeeping, latency counter, cancel flag and the registered RAM command.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r          <= 4'd0;
      ownerMem_r     <= 1'b0;
      lastGrantMem_r <= 1'b0;
      isWrite_r      <= 1'b0;
      cancel_r       <= 1'b0;
      ram_en         <= 1'b0;
      ram_we         <= 1'b0;
      ram_addr       <= {ADDR_W{1'b0}};
      ram_wdata      <= {DATA_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (nextState_s == CMD) begin
            ownerMem_r     <= grantMem_s;
            lastGrantMem_r <= grantMem_s;
            isWrite_r      <= grantMem_s & mem_wr;
            ram_en         <= 1'b1;
            ram_we         <= grantMem_s & mem_wr;
            ram_addr       <= grantMem_s ? mem_addr : if_addr;
            ram_wdata      <= grantMem_s ? mem_wdata : {DATA_W{1'b0}};
          end
        end
        CMD: begin
          ram_en <= 1'b0;
          ram_we <= 1'b0;
          cnt_r  <= LAT_INIT;
          if (cancelHit_s) cancel_r <= 1'b1;
        end
        WAIT: begin
          cnt_r <= cnt_r - 4'd1;
          if (cancelHit_s) cancel_r <= 1'b1;
        end
        RESP:    cancel_r <= 1'b0;
        default: cancel_r <= 1'b0;
      endcase
    end
  end

  // Response capture; a cancel seen up to the capture edge drops the fetch result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_ready  <= 1'b0;
      mem_ready <= 1'b0;
      if_rdata  <= {DATA_W{1'b0}};
      mem_rdata <= {DATA_W{1'b0}};
    end else begin
      if_ready  <= 1'b0;
      mem_ready <= 1'b0;
      if (lastWait_s) begin
        if (ownerMem_r) begin
          mem_ready <= 1'b1;
          if (!isWrite_r) mem_rdata <= ram_rdata;
        end else if (!(cancel_r || if_cancel)) begin
          if_ready <= 1'b1;
          if_rdata <= ram_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table plus hand-written
// sequences for contention, cancel and mid-transaction reset.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int MEM_LAT = 2;
  localparam int LAT     = MEM_LAT + 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              if_req, if_cancel, if_ready;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              mem_rd, mem_wr, mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic              stall_if, stall_mem;
  logic              ram_en, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_cancel(if_cancel),
    .if_rdata(if_rdata), .if_ready(if_ready),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .stall_if(stall_if), .stall_mem(stall_mem),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // RAM model: data is driven only in cycle C+MEM_LAT, garbage otherwise.
  int          cyc = 0;
  int          cmdCycle = -100;
  logic [5:0]  cmdIdx = 6'd0;
  logic [31:0] ramModel [0:63];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cyc == 0) begin
      for (int i = 0; i < 64; i++) ramModel[i] <= 32'h0;
      ramModel[16] <= 32'h2010_0005;
      ramModel[32] <= 32'hCAFE_F00D;
      ramModel[33] <= 32'h1111_2222;
      ramModel[34] <= 32'h3333_4444;
    end else if (ram_en) begin
      cmdCycle <= cyc;
      cmdIdx   <= ram_addr[7:2];
      if (ram_we) ramModel[ram_addr[7:2]] <= ram_wdata;
    end
  end
  assign ram_rdata = (cyc == cmdCycle + MEM_LAT) ? ramModel[cmdIdx] : 32'hBAD0_BAD0;

  typedef struct {
    logic        isMem;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic        isMem;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] expData;
  } vec_t;

  exp_t        sb[$];
  vec_t        vecs[7];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] lastIfData = 32'h0;
  logic [31:0] lastMemData = 32'h0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every ready pulse pops the oldest expected completion.
  task automatic monitor();
    exp_t e;
    if (if_ready || mem_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_ready", {30'd0, if_ready, mem_ready}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("ready_port", {31'd0, mem_ready}, {31'd0, e.isMem});
        if (e.isMem) chk("mem_rdata", mem_rdata, e.data);
        else         chk("if_rdata", if_rdata, e.data);
      end
    end
  endtask

  task automatic negSample();
    @(negedge clk);
    monitor();
  endtask

  task automatic posDrive();
    @(posedge clk);
    #1;
  endtask

  task automatic runVec(int idx, vec_t v);
    int lat;
    lat = -1;
    if (v.isMem) begin
      mem_rd = ~v.wr; mem_wr = v.wr; mem_addr = v.addr; mem_wdata = v.wdata;
      if (!v.wr) lastMemData = v.expData;
      sb.push_back('{1'b1, lastMemData});
    end else begin
      if_req = 1'b1; if_addr = v.addr;
      lastIfData = v.expData;
      sb.push_back('{1'b0, v.expData});
    end
    for (int k = 0; k < 20 && lat < 0; k++) begin
      negSample();
      chk($sformatf("v%0d_ram_en_k%0d", idx, k), {31'd0, ram_en}, {31'd0, k == 1});
      if (k == 1) begin
        chk($sformatf("v%0d_ram_addr", idx), ram_addr, v.addr);
        chk($sformatf("v%0d_ram_we", idx), {31'd0, ram_we}, {31'd0, v.isMem & v.wr});
        if (v.isMem && v.wr) chk($sformatf("v%0d_ram_wdata", idx), ram_wdata, v.wdata);
      end
      chk($sformatf("v%0d_stall_if_k%0d", idx, k), {31'd0, stall_if}, {31'd0, k < LAT});
      chk($sformatf("v%0d_stall_mem_k%0d", idx, k), {31'd0, stall_mem},
          {31'd0, v.isMem && (k < LAT)});
      if (if_ready || mem_ready) lat = k;
      posDrive();
    end
    chk($sformatf("v%0d_latency", idx), 32'(lat), 32'(LAT));
    if_req = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
  endtask

  logic [31:0] grants[4];
  int          ng, nr;

  initial begin
    vecs[0] = '{1'b0, 1'b0, 32'h0000_0040, 32'h0,          32'h2010_0005};
    vecs[1] = '{1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,          32'hDEAD_BEEF};
    vecs[3] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,          32'hDEAD_BEEF};
    vecs[4] = '{1'b1, 1'b1, 32'h0000_0044, 32'h1234_5678, 32'h0};
    vecs[5] = '{1'b1, 1'b0, 32'h0000_0044, 32'h0,          32'h1234_5678};
    vecs[6] = '{1'b0, 1'b0, 32'h0000_0080, 32'h0,          32'hCAFE_F00D};

    reset = 1'b1; if_req = 1'b0; if_cancel = 1'b0; if_addr = 32'h0;
    mem_rd = 1'b0; mem_wr = 1'b0; mem_addr = 32'h0; mem_wdata = 32'h0;
    negSample();
    chk("rst_ram_en", {31'd0, ram_en}, 32'd0);
    chk("rst_ram_addr", ram_addr, 32'd0);
    chk("rst_ready", {30'd0, if_ready, mem_ready}, 32'd0);
    chk("rst_rdata", if_rdata | mem_rdata, 32'd0);
    repeat (2) posDrive();
    reset = 1'b0;

    for (int i = 0; i < 7; i++) runVec(i, vecs[i]);

    // Contention: MEM first (ready k=4), IF CMD at k=6, ready k=9.
    if_req = 1'b1; if_addr = 32'h40; mem_rd = 1'b1; mem_addr = 32'h44;
    sb.push_back('{1'b1, 32'h1234_5678}); lastMemData = 32'h1234_5678;
    sb.push_back('{1'b0, 32'h2010_0005}); lastIfData = 32'h2010_0005;
    for (int k = 0; k < 10; k++) begin
      negSample();
      chk($sformatf("cont_ram_en_k%0d", k), {31'd0, ram_en}, {31'd0, k == 1 || k == 6});
      if (k == 1) chk("cont_addr_mem", ram_addr, 32'h44);
      if (k == 6) chk("cont_addr_if", ram_addr, 32'h40);
      chk($sformatf("cont_mem_ready_k%0d", k), {31'd0, mem_ready}, {31'd0, k == 4});
      chk($sformatf("cont_if_ready_k%0d", k), {31'd0, if_ready}, {31'd0, k == 9});
      chk($sformatf("cont_stall_if_k%0d", k), {31'd0, stall_if}, {31'd0, k < 9});
      posDrive();
      if (k == 4) mem_rd = 1'b0;
      if (k == 9) if_req = 1'b0;
    end

    // Alternating contention with both ports continuously requesting.
    if_req = 1'b1; if_addr = 32'h84; mem_rd = 1'b1; mem_addr = 32'h88;
    sb.push_back('{1'b1, 32'h3333_4444});
    sb.push_back('{1'b0, 32'h1111_2222});
    sb.push_back('{1'b1, 32'h3333_4444});
    sb.push_back('{1'b0, 32'h1111_2222});
    lastMemData = 32'h3333_4444; lastIfData = 32'h1111_2222;
    ng = 0; nr = 0;
    for (int k = 0; k < 60 && nr < 4; k++) begin
      negSample();
      if (ram_en && ng < 4) begin grants[ng] = ram_addr; ng++; end
      if (if_ready || mem_ready) nr++;
      posDrive();
    end
    if_req = 1'b0; mem_rd = 1'b0;
    chk("alt_ready_count", 32'(nr), 32'd4);
    chk("alt_grant_count", 32'(ng), 32'd4);
    for (int g = 0; g < 4; g++)
      chk($sformatf("alt_grant%0d", g), grants[g], (g % 2 == 0) ? 32'h88 : 32'h84);

    // Fetch cancelled in WAIT; the next fetch is sampled right after RESP.
    if_req = 1'b1; if_addr = 32'h40;
    for (int k = 0; k < 10; k++) begin
      negSample();
      chk($sformatf("can_ram_en_k%0d", k), {31'd0, ram_en}, {31'd0, k == 1 || k == 6});
      if (k == 4) begin
        chk("can_if_ready", {31'd0, if_ready}, 32'd0);
        chk("can_if_rdata_hold", if_rdata, 32'h1111_2222);
      end
      if (k == 6) chk("can_next_addr", ram_addr, 32'h80);
      if (k == 9) chk("can_next_ready", {31'd0, if_ready}, 32'd1);
      posDrive();
      if (k == 1) if_cancel = 1'b1;
      if (k == 2) if_cancel = 1'b0;
      if (k == 4) begin
        if_addr = 32'h80;
        sb.push_back('{1'b0, 32'hCAFE_F00D}); lastIfData = 32'hCAFE_F00D;
      end
      if (k == 9) if_req = 1'b0;
    end

    // Reset asserted during WAIT of a load aborts it with no ready.
    mem_rd = 1'b1; mem_addr = 32'h10;
    for (int k = 0; k < 3; k++) begin
      negSample();
      if (k < 2) posDrive();
    end
    #2;
    reset = 1'b1; mem_rd = 1'b0;
    #1;
    chk("mrst_ram_en", {31'd0, ram_en}, 32'd0);
    chk("mrst_ram_we", {31'd0, ram_we}, 32'd0);
    chk("mrst_ram_addr", ram_addr, 32'd0);
    chk("mrst_ram_wdata", ram_wdata, 32'd0);
    chk("mrst_ready", {30'd0, if_ready, mem_ready}, 32'd0);
    chk("mrst_if_rdata", if_rdata, 32'd0);
    chk("mrst_mem_rdata", mem_rdata, 32'd0);
    chk("mrst_stalls", {30'd0, stall_if, stall_mem}, 32'd0);
    lastIfData = 32'h0; lastMemData = 32'h0;
    repeat (2) begin posDrive(); negSample(); end
    posDrive();
    reset = 1'b0;
    repeat (4) begin
      negSample();
      chk("mrst_no_ready", {30'd0, if_ready, mem_ready}, 32'd0);
      posDrive();
    end
    runVec(7, '{1'b1, 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF});

    repeat (3) begin negSample(); posDrive(); end
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
